// File: rtl/proc_pkg.sv
// proc_pkg: definitions shared across the 5-stage core.
//   - DEF_DATA_WIDTH / DEF_REG_ADDR_W : default operand and register-address widths
//   - OP_* : 3-bit ALU opcode encodings
//   - fwd_sel_e : operand source chosen by the EX-stage forwarding mux
package proc_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_REG_ADDR_W = 5;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: groups the ID/EX stage's pipeline-control, ID-side, forwarding and
// EX-side signals.
//   master : the surrounding pipeline (drives ID fields, stall/flush, forward sources)
//   slave  : the ID/EX stage (drives ex_* outputs and load_use_hazard)
interface id_ex_stage_if #(
  parameter int DATA_WIDTH = proc_pkg::DEF_DATA_WIDTH,
  parameter int REG_ADDR_W = proc_pkg::DEF_REG_ADDR_W
);

  logic                  stall;
  logic                  flush;

  logic                  id_valid;
  logic [2:0]            id_opcode;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic [DATA_WIDTH-1:0] id_rs1_data;
  logic [DATA_WIDTH-1:0] id_rs2_data;
  logic [DATA_WIDTH-1:0] id_imm;
  logic                  id_use_imm;
  logic                  id_reg_write;
  logic                  id_mem_read;

  logic                  exmem_reg_write;
  logic [REG_ADDR_W-1:0] exmem_rd;
  logic [DATA_WIDTH-1:0] exmem_result;
  logic                  memwb_reg_write;
  logic [REG_ADDR_W-1:0] memwb_rd;
  logic [DATA_WIDTH-1:0] memwb_data;

  logic                  ex_valid;
  logic [2:0]            ex_opcode;
  logic [DATA_WIDTH-1:0] ex_alu_in1;
  logic [DATA_WIDTH-1:0] ex_alu_in2;
  logic [DATA_WIDTH-1:0] ex_store_data;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_reg_write;
  logic                  ex_mem_read;
  logic                  load_use_hazard;

  modport master (
    output stall, flush,
    output id_valid, id_opcode, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
           id_imm, id_use_imm, id_reg_write, id_mem_read,
    output exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_data,
    input  ex_valid, ex_opcode, ex_alu_in1, ex_alu_in2, ex_store_data,
           ex_rd, ex_reg_write, ex_mem_read, load_use_hazard
  );

  modport slave (
    input  stall, flush,
    input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
           id_imm, id_use_imm, id_reg_write, id_mem_read,
    input  exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_data,
    output ex_valid, ex_opcode, ex_alu_in1, ex_alu_in2, ex_store_data,
           ex_rd, ex_reg_write, ex_mem_read, load_use_hazard
  );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux: operand-forwarding select and 3:1 data mux for one EX source operand.
//   i_rs / i_reg_data           : registered source register number and its read data
//   i_exmem_* / i_memwb_*       : write-back candidates from the EX/MEM and MEM/WB stages
//   o_data                      : forwarded operand value
// EX/MEM has priority over MEM/WB; register 0 is never forwarded.
module fwd_mux
  import proc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] i_rs,
  input  logic [DATA_WIDTH-1:0] i_reg_data,
  input  logic                  i_exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] i_exmem_rd,
  input  logic [DATA_WIDTH-1:0] i_exmem_result,
  input  logic                  i_memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] i_memwb_rd,
  input  logic [DATA_WIDTH-1:0] i_memwb_data,
  output logic [DATA_WIDTH-1:0] o_data
);

  fwd_sel_e w_sel;

  always_comb begin
    w_sel = FWD_REG;
    if (i_exmem_reg_write && (i_exmem_rd != '0) && (i_exmem_rd == i_rs)) begin
      w_sel = FWD_EXMEM;
    end else if (i_memwb_reg_write && (i_memwb_rd != '0) && (i_memwb_rd == i_rs)) begin
      w_sel = FWD_MEMWB;
    end
  end

  always_comb begin
    case (w_sel)
      FWD_EXMEM: o_data = i_exmem_result;
      FWD_MEMWB: o_data = i_memwb_data;
      default:   o_data = i_reg_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX-side operand forwarding and load-use
// hazard detection.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : id_ex_stage_if.slave -- stall/flush, ID fields, EX/MEM and MEM/WB forward
//          sources in; ALU operands/opcode, EX control and load_use_hazard out
// Build option: define ID_EX_FWD_EN to enable forwarding. Without it the forward inputs
// are ignored, operands come straight from the registers, and load_use_hazard stalls on
// any valid register-writing EX instruction whose rd matches an ID source.
module id_ex_stage
  import proc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic        clk,
  input  logic        rst,
  id_ex_stage_if.slave bus
);

  logic                  r_valid;
  logic [2:0]            r_opcode;
  logic [REG_ADDR_W-1:0] r_rs1;
  logic [REG_ADDR_W-1:0] r_rs2;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [DATA_WIDTH-1:0] r_rs1_data;
  logic [DATA_WIDTH-1:0] r_rs2_data;
  logic [DATA_WIDTH-1:0] r_imm;
  logic                  r_use_imm;
  logic                  r_reg_write;
  logic                  r_mem_read;

  logic                  w_src_hit;
  logic                  w_hazard;
  logic                  w_clear;
  logic [DATA_WIDTH-1:0] w_fwd_rs1;
  logic [DATA_WIDTH-1:0] w_fwd_rs2;

  // rs2 only counts as a source when the instruction actually reads it.
  assign w_src_hit = bus.id_valid && (r_rd != '0) &&
                     ((bus.id_rs1 == r_rd) || (!bus.id_use_imm && (bus.id_rs2 == r_rd)));

`ifdef ID_EX_FWD_EN
  assign w_hazard = r_valid && r_mem_read && w_src_hit;
`else
  assign w_hazard = r_valid && r_reg_write && w_src_hit;
`endif

  // Flush and a hazard bubble both zero the stage; stall outranks the bubble but not flush.
  assign w_clear = bus.flush || (!bus.stall && w_hazard);

  always_ff @(posedge clk or posedge rst) begin
    if (rst || w_clear) begin
      r_valid     <= 1'b0;
      r_opcode    <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_use_imm   <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
    end else if (!bus.stall) begin
      r_valid     <= bus.id_valid;
      r_opcode    <= bus.id_opcode;
      r_rs1       <= bus.id_rs1;
      r_rs2       <= bus.id_rs2;
      r_rd        <= bus.id_rd;
      r_rs1_data  <= bus.id_rs1_data;
      r_rs2_data  <= bus.id_rs2_data;
      r_imm       <= bus.id_imm;
      r_use_imm   <= bus.id_use_imm;
      r_reg_write <= bus.id_reg_write && bus.id_valid;
      r_mem_read  <= bus.id_mem_read && bus.id_valid;
    end
  end

`ifdef ID_EX_FWD_EN
  fwd_mux #(
    .DATA_WIDTH(DATA_WIDTH),
    .REG_ADDR_W(REG_ADDR_W)
  ) u_fwd_rs1 (
    .i_rs              (r_rs1),
    .i_reg_data        (r_rs1_data),
    .i_exmem_reg_write (bus.exmem_reg_write),
    .i_exmem_rd        (bus.exmem_rd),
    .i_exmem_result    (bus.exmem_result),
    .i_memwb_reg_write (bus.memwb_reg_write),
    .i_memwb_rd        (bus.memwb_rd),
    .i_memwb_data      (bus.memwb_data),
    .o_data            (w_fwd_rs1)
  );

  fwd_mux #(
    .DATA_WIDTH(DATA_WIDTH),
    .REG_ADDR_W(REG_ADDR_W)
  ) u_fwd_rs2 (
    .i_rs              (r_rs2),
    .i_reg_data        (r_rs2_data),
    .i_exmem_reg_write (bus.exmem_reg_write),
    .i_exmem_rd        (bus.exmem_rd),
    .i_exmem_result    (bus.exmem_result),
    .i_memwb_reg_write (bus.memwb_reg_write),
    .i_memwb_rd        (bus.memwb_rd),
    .i_memwb_data      (bus.memwb_data),
    .o_data            (w_fwd_rs2)
  );
`else
  assign w_fwd_rs1 = r_rs1_data;
  assign w_fwd_rs2 = r_rs2_data;

  logic w_unused_fwd;
  assign w_unused_fwd = ^{r_rs1, r_rs2, bus.exmem_reg_write, bus.exmem_rd, bus.exmem_result,
                          bus.memwb_reg_write, bus.memwb_rd, bus.memwb_data};
`endif

  assign bus.ex_valid        = r_valid;
  assign bus.ex_opcode       = r_opcode;
  assign bus.ex_alu_in1      = w_fwd_rs1;
  assign bus.ex_alu_in2      = r_use_imm ? r_imm : w_fwd_rs2;
  assign bus.ex_store_data   = w_fwd_rs2;
  assign bus.ex_rd           = r_rd;
  assign bus.ex_reg_write    = r_reg_write;
  assign bus.ex_mem_read     = r_mem_read;
  assign bus.load_use_hazard = w_hazard;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  import proc_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int OW = 3 * DW + AW + 7;
`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef logic [OW-1:0] out_t;

  typedef struct {
    bit          valid;
    logic [2:0]  opc;
    logic [AW-1:0] rs1, rs2, rd;
    logic [DW-1:0] d1, d2, imm;
    bit          use_imm, rw, mr;
  } ex_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_WIDTH(DW), .REG_ADDR_W(AW)) bus ();

  id_ex_stage #(.DATA_WIDTH(DW), .REG_ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  ex_t st;

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] m_fwd(input logic [AW-1:0] rs, input logic [DW-1:0] d);
    if (FWD && bus.exmem_reg_write && bus.exmem_rd != 0 && bus.exmem_rd == rs) return bus.exmem_result;
    if (FWD && bus.memwb_reg_write && bus.memwb_rd != 0 && bus.memwb_rd == rs) return bus.memwb_data;
    return d;
  endfunction

  function automatic bit m_hazard();
    bit src;
    src = st.valid && st.rd != 0 && bus.id_valid &&
          (bus.id_rs1 == st.rd || (!bus.id_use_imm && bus.id_rs2 == st.rd));
    return src && (FWD ? st.mr : st.rw);
  endfunction

  function automatic out_t m_out();
    logic [DW-1:0] f2;
    f2 = m_fwd(st.rs2, st.d2);
    return {st.valid, st.opc, m_fwd(st.rs1, st.d1), (st.use_imm ? st.imm : f2), f2,
            st.rd, st.rw, st.mr, m_hazard()};
  endfunction

  function automatic out_t dut_out();
    return {bus.ex_valid, bus.ex_opcode, bus.ex_alu_in1, bus.ex_alu_in2, bus.ex_store_data,
            bus.ex_rd, bus.ex_reg_write, bus.ex_mem_read, bus.load_use_hazard};
  endfunction

  // Advance the model by one clock using the inputs currently presented, then step the DUT.
  task automatic tick();
    ex_t nx;
    nx = '{default: 0};
    if (!rst && !bus.flush) begin
      if (bus.stall) nx = st;
      else if (!m_hazard()) begin
        nx.valid   = bus.id_valid;
        nx.opc     = bus.id_opcode;
        nx.rs1     = bus.id_rs1;
        nx.rs2     = bus.id_rs2;
        nx.rd      = bus.id_rd;
        nx.d1      = bus.id_rs1_data;
        nx.d2      = bus.id_rs2_data;
        nx.imm     = bus.id_imm;
        nx.use_imm = bus.id_use_imm;
        nx.rw      = bus.id_reg_write && bus.id_valid;
        nx.mr      = bus.id_mem_read && bus.id_valid;
      end
    end
    @(posedge clk);
    #1;
    st = nx;
  endtask

  task automatic set_idle();
    bus.stall = 0; bus.flush = 0;
    bus.id_valid = 0; bus.id_opcode = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
    bus.id_rs1_data = 0; bus.id_rs2_data = 0; bus.id_imm = 0; bus.id_use_imm = 0;
    bus.id_reg_write = 0; bus.id_mem_read = 0;
    bus.exmem_reg_write = 0; bus.exmem_rd = 0; bus.exmem_result = 0;
    bus.memwb_reg_write = 0; bus.memwb_rd = 0; bus.memwb_data = 0;
  endtask

  task automatic set_id(input bit v, input logic [2:0] opc, input logic [AW-1:0] rs1, rs2, rd,
                        input logic [DW-1:0] d1, d2, imm, input bit ui, rw, mr);
    bus.id_valid = v; bus.id_opcode = opc; bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
    bus.id_rs1_data = d1; bus.id_rs2_data = d2; bus.id_imm = imm; bus.id_use_imm = ui;
    bus.id_reg_write = rw; bus.id_mem_read = mr;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1; set_idle(); st = '{default: 0};
    tick(); tick();
    checks++;
    if (dut_out() !== m_out()) begin
      errors++; $display("FAIL reset_state got=%h exp=%h", dut_out(), m_out());
    end
    rst = 0;
    set_id(1, OP_ADD, 1, 2, 9, 32'h11, 32'h22, 0, 0, 1, 1);
    tick();
    checks++;
    if (dut_out() !== m_out()) begin
      errors++; $display("FAIL capture got=%h exp=%h", dut_out(), m_out());
    end
    #2 rst = 1;
    #1 st = '{default: 0};
    checks++;
    if ({bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read} !== 3'b000) begin
      errors++; $display("FAIL async_reset_ctrl got=%b exp=000",
                         {bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read});
    end
    checks++;
    if (dut_out() !== m_out()) begin
      errors++; $display("FAIL async_reset_all got=%h exp=%h", dut_out(), m_out());
    end
    tick();
    rst = 0;
  endtask

  task automatic test_forward();
    logic [DW-1:0] exp;
    set_idle();
    set_id(1, OP_ADD, 3, 6, 10, 32'd5, 32'h66, 0, 0, 1, 0);
    tick();
    set_idle();
    bus.exmem_reg_write = 1; bus.exmem_rd = 3; bus.exmem_result = 32'h64;
    bus.memwb_reg_write = 1; bus.memwb_rd = 3; bus.memwb_data = 32'h7;
    #1;
    exp = FWD ? 32'h64 : 32'd5;
    checks++;
    if (bus.ex_alu_in1 !== exp) begin
      errors++; $display("FAIL fwd_exmem_priority got=%h exp=%h", bus.ex_alu_in1, exp);
    end
    checks++;
    if (dut_out() !== m_out()) begin
      errors++; $display("FAIL fwd_both got=%h exp=%h", dut_out(), m_out());
    end
    bus.exmem_reg_write = 0;
    #1;
    exp = FWD ? 32'h7 : 32'd5;
    checks++;
    if (bus.ex_alu_in1 !== exp) begin
      errors++; $display("FAIL fwd_memwb got=%h exp=%h", bus.ex_alu_in1, exp);
    end
    set_idle();
    set_id(1, OP_OR, 1, 0, 11, 32'h9, 32'h0, 0, 0, 1, 0);
    tick();
    set_idle();
    bus.exmem_reg_write = 1; bus.exmem_rd = 0; bus.exmem_result = 32'hFF;
    #1;
    checks++;
    if (bus.ex_alu_in2 !== 32'h0) begin
      errors++; $display("FAIL no_fwd_r0 got=%h exp=00000000", bus.ex_alu_in2);
    end
    checks++;
    if (dut_out() !== m_out()) begin
      errors++; $display("FAIL no_fwd_r0_all got=%h exp=%h", dut_out(), m_out());
    end
  endtask

  task automatic test_load_use();
    set_idle();
    set_id(1, OP_ADD, 1, 2, 4, 32'h40, 32'h0, 32'h8, 1, 1, 1);
    tick();
    set_id(1, OP_ADD, 1, 4, 5, 32'h1, 32'h2, 0, 0, 1, 0);
    #1;
    checks++;
    if (bus.load_use_hazard !== 1'b1) begin
      errors++; $display("FAIL load_use_rs2 got=%b exp=1", bus.load_use_hazard);
    end
    tick();
    checks++;
    if (bus.ex_valid !== 1'b0 || dut_out() !== m_out()) begin
      errors++; $display("FAIL load_use_bubble got=%h exp=%h", dut_out(), m_out());
    end
    set_id(1, OP_ADD, 1, 2, 4, 32'h40, 32'h0, 32'h8, 1, 1, 1);
    tick();
    set_id(1, OP_ADD, 2, 4, 5, 32'h1, 32'h2, 32'h3, 1, 1, 0);
    #1;
    checks++;
    if (bus.load_use_hazard !== 1'b0) begin
      errors++; $display("FAIL load_use_imm_no got=%b exp=0", bus.load_use_hazard);
    end
    tick();
    checks++;
    if (bus.ex_valid !== 1'b1 || dut_out() !== m_out()) begin
      errors++; $display("FAIL load_use_imm_capture got=%h exp=%h", dut_out(), m_out());
    end
  endtask

  task automatic test_flush_stall();
    out_t snap, got;
    set_idle();
    set_id(1, OP_SUB, 1, 2, 7, 32'hA, 32'hB, 0, 0, 1, 0);
    tick();
    bus.flush = 1; bus.stall = 1;
    tick();
    bus.flush = 0; bus.stall = 0;
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0) begin
      errors++; $display("FAIL flush_over_stall got=%b%b exp=00", bus.ex_valid, bus.ex_reg_write);
    end
    set_id(1, OP_MUL, 8, 9, 12, 32'hDEAD0001, 32'hBEEF0002, 32'h33, 0, 1, 1);
    tick();
    set_idle();
    #1;
    snap = m_out();
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_id($urandom_range(0, 1), 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
             $urandom, $urandom, $urandom, $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 1));
      tick();
      got = dut_out();
      checks++;
      if (got[OW-1:1] !== snap[OW-1:1]) begin
        errors++; $display("FAIL stall_hold[%0d] got=%h exp=%h", i, got[OW-1:1], snap[OW-1:1]);
      end
    end
    set_idle();
  endtask

  task automatic test_imm();
    logic [DW-1:0] exp_sd;
    set_idle();
    bus.memwb_reg_write = 1; bus.memwb_rd = 7; bus.memwb_data = 32'hAB;
    set_id(1, OP_SUB, 2, 7, 13, 32'h10, 32'h1234, 32'hFFFFFFF0, 1, 1, 0);
    tick();
    exp_sd = FWD ? 32'hAB : 32'h1234;
    checks++;
    if (bus.ex_alu_in2 !== 32'hFFFFFFF0) begin
      errors++; $display("FAIL imm_in2 got=%h exp=fffffff0", bus.ex_alu_in2);
    end
    checks++;
    if (bus.ex_opcode !== 3'b011) begin
      errors++; $display("FAIL imm_opcode got=%b exp=011", bus.ex_opcode);
    end
    checks++;
    if (bus.ex_store_data !== exp_sd) begin
      errors++; $display("FAIL imm_store_data got=%h exp=%h", bus.ex_store_data, exp_sd);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.flush = ($urandom_range(0, 15) == 0);
      bus.stall = ($urandom_range(0, 9) == 0);
      set_id($urandom_range(0, 7) != 0, 3'($urandom), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 2) == 0);
      bus.exmem_reg_write = $urandom_range(0, 1); bus.exmem_rd = 5'($urandom_range(0, 7));
      bus.exmem_result = $urandom;
      bus.memwb_reg_write = $urandom_range(0, 1); bus.memwb_rd = 5'($urandom_range(0, 7));
      bus.memwb_data = $urandom;
      #1;
      checks++;
      if (dut_out() !== m_out()) begin
        errors++; $display("FAIL random[%0d] got=%h exp=%h", i, dut_out(), m_out());
      end
      tick();
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_flush_stall();
    test_imm();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
